// File: rtl/regfile_rd2w1_if.sv
// Bundle of the writeback write port, the two decode read ports and the write counter.
interface regfile_rd2w1_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned CNT_W = 8;

  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output we, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_count
  );

  modport slave (
    input  we, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_count
  );
endinterface

// File: rtl/regfile_rd2w1.sv
// Architectural register file: one write port, two combinational read ports with
// optional write-through bypass, register 0 hardwired to zero, saturating write counter.
module regfile_rd2w1 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic           clk,
  input  logic           clr,
  regfile_rd2w1_if.slave rf
);
  localparam int unsigned CNT_W = 8;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  wr_en_c;
  logic              commit_c;
  logic [CNT_W-1:0]  wr_count_q;
  logic [CNT_W-1:0]  wr_count_d;
  logic [DATA_W-1:0] rd_a_c;
  logic [DATA_W-1:0] rd_b_c;

  // A write to register 0 is a no-op and does not count as a commit.
  assign commit_c = rf.we && (rf.wr_addr != '0);

  always_comb begin
    wr_en_c = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      wr_en_c[i] = commit_c && (rf.wr_addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (wr_en_c[i]) begin
          regs_q[i] <= rf.wr_data;
        end
      end
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (commit_c && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  // Read ports: stored value, then bypass, with clear and register 0 taking final priority.
  always_comb begin
    rd_a_c = regs_q[rf.rd_addr_a];
    if ((BYPASS != 0) && commit_c && (rf.wr_addr == rf.rd_addr_a)) begin
      rd_a_c = rf.wr_data;
    end
    if (clr || (rf.rd_addr_a == '0)) begin
      rd_a_c = '0;
    end
  end

  always_comb begin
    rd_b_c = regs_q[rf.rd_addr_b];
    if ((BYPASS != 0) && commit_c && (rf.wr_addr == rf.rd_addr_b)) begin
      rd_b_c = rf.wr_data;
    end
    if (clr || (rf.rd_addr_b == '0)) begin
      rd_b_c = '0;
    end
  end

  assign rf.rd_data_a = rd_a_c;
  assign rf.rd_data_b = rd_b_c;
  assign rf.wr_count  = wr_count_q;
endmodule

// File: tb/tb_regfile_rd2w1.sv
// Bench for regfile_rd2w1: a bypassing and a non-bypassing instance driven in lockstep.
module tb_regfile_rd2w1;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd_a = '0;
  logic [4:0]  rd_b = '0;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned model_regs [32];
  int unsigned model_cnt;

  always #5 clk = ~clk;

  regfile_rd2w1_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
  regfile_rd2w1_if #(.DATA_W(32), .ADDR_W(5)) if_n ();

  assign if_b.we = we;        assign if_n.we = we;
  assign if_b.wr_addr = wr_addr; assign if_n.wr_addr = wr_addr;
  assign if_b.wr_data = wr_data; assign if_n.wr_data = wr_data;
  assign if_b.rd_addr_a = rd_a; assign if_n.rd_addr_a = rd_a;
  assign if_b.rd_addr_b = rd_b; assign if_n.rd_addr_b = rd_b;

  regfile_rd2w1 #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .BYPASS(1)) dut (
    .clk(clk), .clr(clr), .rf(if_b)
  );
  regfile_rd2w1 #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .BYPASS(0)) dut_nb (
    .clk(clk), .clr(clr), .rf(if_n)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;   // bypassing instance, before the edge
    logic [31:0] exp_b;
    logic [31:0] exp_na;  // non-bypassing instance, before the edge
    logic [31:0] exp_nb;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit bypass);
    if (clr || a == 0) return 32'h0;
    if (bypass && we && wr_addr != 0 && wr_addr == a) return wr_data;
    return model_regs[a];
  endfunction

  task automatic model_clear();
    foreach (model_regs[i]) model_regs[i] = 0;
    model_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".byp_a"}, if_b.rd_data_a, exp_rd(rd_a, 1'b1));
    chk({tag, ".byp_b"}, if_b.rd_data_b, exp_rd(rd_b, 1'b1));
    chk({tag, ".nb_a"}, if_n.rd_data_a, exp_rd(rd_a, 1'b0));
    chk({tag, ".nb_b"}, if_n.rd_data_b, exp_rd(rd_b, 1'b0));
    chk({tag, ".cnt"}, 32'(if_b.wr_count), model_cnt);
    chk({tag, ".cnt_nb"}, 32'(if_n.wr_count), model_cnt);
  endtask

  // Advance through one rising edge, committing to the model, then settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    if (!clr && we && wr_addr != 0) begin
      model_regs[wr_addr] = wr_data;
      if (model_cnt < 255) model_cnt++;
    end
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a, input logic [4:0] b);
    we = w; wr_addr = wa; wr_data = wd; rd_a = a; rd_b = b;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 8'd0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 8'd1};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 8'd1};
    vecs[3] = '{1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 8'd1};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 8'd2};

    // Mid-cycle clear pulse, no clock edge inside it.
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
    #7 clr = 1'b1;
    model_clear();
    #1 chk("reset_during.a7", if_b.rd_data_a, 32'h0);
    #2 clr = 1'b0;
    #2;
    chk("reset.a7", if_b.rd_data_a, 32'h0);
    chk("reset.b31", if_b.rd_data_b, 32'h0);
    chk("reset.cnt", 32'(if_b.wr_count), 32'h0);
    chk("reset.nb_b31", if_n.rd_data_b, 32'h0);

    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      #1;
      chk($sformatf("vec%0d.a", i), if_b.rd_data_a, vecs[i].exp_a);
      chk($sformatf("vec%0d.b", i), if_b.rd_data_b, vecs[i].exp_b);
      chk($sformatf("vec%0d.na", i), if_n.rd_data_a, vecs[i].exp_na);
      chk($sformatf("vec%0d.nb", i), if_n.rd_data_b, vecs[i].exp_nb);
      chk($sformatf("vec%0d.cnt", i), 32'(if_b.wr_count), 32'(vecs[i].exp_cnt));
      tick();
    end

    // Clear wins over a concurrent write and over bypass.
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    #1 chk("clrpri.pre", if_b.rd_data_a, 32'hA5A5A5A5);
    clr = 1'b1;
    model_clear();
    drive(1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
    #1;
    chk("clrpri.byp_a", if_b.rd_data_a, 32'h0);
    chk("clrpri.nb_a", if_n.rd_data_a, 32'h0);
    tick();
    chk("clrpri.edge_a", if_b.rd_data_a, 32'h0);
    chk("clrpri.edge_cnt", 32'(if_b.wr_count), 32'h0);
    clr = 1'b0;
    drive(1'b0, 5'd3, 32'h1, 5'd3, 5'd3);
    tick();
    chk("clrpri.after_a", if_b.rd_data_a, 32'h0);
    chk("clrpri.after_nb", if_n.rd_data_b, 32'h0);
    check_all("clrpri");

    // Randomized traffic against the model, with occasional mid-cycle clear pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        clr = 1'b1;
        model_clear();
        #2 clr = 1'b0;
      end
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 2) == 0) rd_a = wr_addr;
      if ($urandom_range(0, 2) == 0) rd_b = wr_addr;
      #1 check_all($sformatf("rnd%0d", i));
      tick();
    end

    // Saturation of the write counter.
    clr = 1'b1;
    model_clear();
    #1 clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 5'd1, 32'(i), 5'd1, 5'd2);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd0);
    #1;
    chk("sat.cnt", 32'(if_b.wr_count), 32'd255);
    chk("sat.cnt_nb", 32'(if_n.wr_count), 32'd255);
    chk("sat.r1", if_b.rd_data_a, 32'd299);
    chk("sat.r1_nb", if_n.rd_data_a, 32'd299);
    check_all("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
